// File: rtl/button_arbiter_if.sv
// Button/pulse bundle between the raw push buttons and the mode generator.
// master drives the buttons and observes the pulses; slave is the arbiter.
interface button_arbiter_if;
   logic btn_sw1;
   logic btn_sw2;
   logic btn_set;
   logic sw1;
   logic sw2;
   logic set;
   logic repeat_active;

   modport master (
      output btn_sw1, btn_sw2, btn_set,
      input  sw1, sw2, set, repeat_active
   );

   modport slave (
      input  btn_sw1, btn_sw2, btn_set,
      output sw1, sw2, set, repeat_active
   );
endinterface

// File: rtl/button_arbiter.sv
// Synchronise, debounce and edge-detect SW1/SW2/SET, arbitrate them into single-cycle
// mutually exclusive pulses, and auto-repeat SET while it is held.
module button_arbiter #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_DELAY    = 32,
   parameter int unsigned REPEAT_PERIOD   = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   button_arbiter_if.slave bus
);
   localparam int unsigned NB   = 3;
   localparam int unsigned DCW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RCW  = $clog2(RMAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_state_e;

   // Bit order of every per-button vector: [0]=SW1, [1]=SW2, [2]=SET.
   logic [NB-1:0]          raw_c;
   logic [NB-1:0]          sync1_q;
   logic [NB-1:0]          sync2_q;
   logic [NB-1:0]          deb_q;
   logic [NB-1:0]          deb_d;
   logic [NB-1:0]          deb_prev_q;
   logic [NB-1:0][DCW-1:0] dcnt_q;
   logic [NB-1:0][DCW-1:0] dcnt_d;
   logic [NB-1:0]          rise_c;
   logic [NB-1:0]          fall_c;
   logic [NB-1:0]          pend_q;
   logic [NB-1:0]          pend_d;
   logic [NB-1:0]          out_q;
   logic [NB-1:0]          out_d;
   rep_state_e             state_q;
   rep_state_e             state_d;
   logic [RCW-1:0]         rcnt_q;
   logic [RCW-1:0]         rcnt_d;
   logic                   armed_q;
   logic                   armed_d;
   logic                   ract_q;
   logic                   ract_d;
   logic                   cancel_c;
   logic                   fire_c;
   logic                   req_set_c;

   assign raw_c = {bus.btn_set, bus.btn_sw2, bus.btn_sw1};

   assign bus.sw1           = out_q[0];
   assign bus.sw2           = out_q[1];
   assign bus.set           = out_q[2];
   assign bus.repeat_active = ract_q;

   // Returns {level, count}: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   function automatic logic [DCW:0] debounce_step(input logic syn, input logic lvl,
                                                  input logic [DCW-1:0] cnt);
      logic [DCW:0] r;
      r = {lvl, {DCW{1'b0}}};
      if (syn != lvl) begin
         if (cnt == DCW'(DEBOUNCE_CYCLES - 1)) r = {syn, {DCW{1'b0}}};
         else                                  r = {lvl, cnt + DCW'(1)};
      end
      return r;
   endfunction

   always_comb begin
      deb_d  = deb_q;
      dcnt_d = dcnt_q;
      {deb_d[0], dcnt_d[0]} = debounce_step(sync2_q[0], deb_q[0], dcnt_q[0]);
      {deb_d[1], dcnt_d[1]} = debounce_step(sync2_q[1], deb_q[1], dcnt_q[1]);
      {deb_d[2], dcnt_d[2]} = debounce_step(sync2_q[2], deb_q[2], dcnt_q[2]);
   end

   assign rise_c = deb_q & ~deb_prev_q;
   assign fall_c = ~deb_q & deb_prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         dcnt_q     <= '0;
         pend_q     <= '0;
         out_q      <= '0;
         state_q    <= IDLE;
         rcnt_q     <= '0;
         armed_q    <= 1'b0;
         ract_q     <= 1'b0;
      end else begin
         sync1_q    <= raw_c;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         dcnt_q     <= dcnt_d;
         pend_q     <= pend_d;
         out_q      <= out_d;
         state_q    <= state_d;
         rcnt_q     <= rcnt_d;
         armed_q    <= armed_d;
         ract_q     <= ract_d;
      end
   end

   // Arbitration plus auto-repeat next-state; rcnt_q==1 means the counter reaches 0 on this edge.
   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      armed_d   = armed_q;
      out_d     = '0;
      cancel_c  = fall_c[2] | rise_c[0] | rise_c[1];
      fire_c    = (state_q != IDLE) && !cancel_c && (rcnt_q == RCW'(1));
      req_set_c = pend_q[2] | fire_c;

      if (pend_q[0])                     out_d[0] = 1'b1;
      else if (pend_q[1])                out_d[1] = 1'b1;
      else if (req_set_c && !out_q[2])   out_d[2] = 1'b1;

      pend_d[0] = (pend_q[0] & ~out_d[0]) | rise_c[0];
      pend_d[1] = (pend_q[1] & ~out_d[1]) | rise_c[1];
      pend_d[2] = (req_set_c & ~out_d[2]) | rise_c[2];

      case (state_q)
         IDLE: begin
            if (out_d[2] && armed_q && !deb_q[0] && !deb_q[1]) begin
               state_d = DELAY;
               rcnt_d  = RCW'(REPEAT_DELAY);
            end
         end
         DELAY: begin
            if (fire_c) begin
               state_d = REPEAT;
               rcnt_d  = RCW'(REPEAT_PERIOD);
            end else if (rcnt_q != '0) begin
               rcnt_d = rcnt_q - RCW'(1);
            end
         end
         REPEAT: begin
            if (fire_c)                rcnt_d = RCW'(REPEAT_PERIOD);
            else if (rcnt_q != '0)     rcnt_d = rcnt_q - RCW'(1);
         end
         default: state_d = IDLE;
      endcase

      if (cancel_c) begin
         state_d = IDLE;
         rcnt_d  = '0;
      end

      // A repeat may start only once per SET press, and never after it was cancelled.
      if (cancel_c || (state_q == IDLE && state_d == DELAY)) armed_d = 1'b0;
      else if (rise_c[2])                                   armed_d = 1'b1;

      ract_d = (state_d == REPEAT);
   end
endmodule

// File: tb/tb_button_arbiter.sv
// Self-checking bench for button_arbiter: directed scenarios plus randomized button
// activity compared cycle by cycle against a behavioural model.
module tb_button_arbiter;
   localparam int unsigned DEB  = 4;
   localparam int unsigned RDLY = 32;
   localparam int unsigned RPER = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   button_arbiter_if bus();

   button_arbiter #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RDLY),
      .REPEAT_PERIOD  (RPER)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: raw sample history, debounced levels, request flags and an absolute
   // cycle schedule for repeat requests.
   bit [2:0]  m_h0, m_h1, m_deb, m_prev, m_pend, m_out;
   bit [63:0] m_hist [3];
   bit        m_rep_on, m_active, m_armed;
   int        m_cyc, m_next;

   task automatic model_clear();
      m_h0 = '0; m_h1 = '0; m_deb = '0; m_prev = '0; m_pend = '0; m_out = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
      m_rep_on = 1'b0; m_active = 1'b0; m_armed = 1'b0;
      m_cyc = 0; m_next = 0;
   endtask

   task automatic model_edge();
      bit [2:0] rise, fall, g, np, syn;
      bit       cancel, fire, all_diff;
      rise   = m_deb & ~m_prev;
      fall   = ~m_deb & m_prev;
      cancel = fall[2] | rise[0] | rise[1];
      fire   = m_rep_on && !cancel && (m_cyc == m_next);
      g      = '0;
      if (m_pend[0])                         g[0] = 1'b1;
      else if (m_pend[1])                    g[1] = 1'b1;
      else if ((m_pend[2] || fire) && !m_out[2]) g[2] = 1'b1;
      np[0] = (m_pend[0] && !g[0]) || rise[0];
      np[1] = (m_pend[1] && !g[1]) || rise[1];
      np[2] = ((m_pend[2] || fire) && !g[2]) || rise[2];
      if (cancel) begin
         m_rep_on = 1'b0; m_active = 1'b0; m_armed = 1'b0;
      end else if (!m_rep_on && g[2] && m_armed && !m_deb[0] && !m_deb[1]) begin
         m_rep_on = 1'b1; m_next = m_cyc + int'(RDLY); m_armed = 1'b0;
      end else if (fire) begin
         m_next = m_cyc + int'(RPER); m_active = 1'b1;
      end
      if (!cancel && rise[2]) m_armed = 1'b1;
      m_pend = np;
      m_out  = g;
      m_prev = m_deb;
      syn    = m_h1;
      m_h1   = m_h0;
      m_h0   = {bus.btn_set, bus.btn_sw2, bus.btn_sw1};
      for (int b = 0; b < 3; b++) begin
         m_hist[b] = {m_hist[b][62:0], syn[b]};
         all_diff  = 1'b1;
         for (int k = 0; k < int'(DEB); k++) if (m_hist[b][k] == m_deb[b]) all_diff = 1'b0;
         if (all_diff) m_deb[b] = ~m_deb[b];
      end
      m_cyc++;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_clear();
         else          model_edge();
      end
   end

   function automatic logic [3:0] model_vec();
      return {m_out[0], m_out[1], m_out[2], m_active};
   endfunction

   function automatic logic [3:0] dut_vec();
      return {bus.sw1, bus.sw2, bus.set, bus.repeat_active};
   endfunction

   task automatic settle();
      bus.btn_sw1 = 1'b0; bus.btn_sw2 = 1'b0; bus.btn_set = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.btn_sw1 = 1'b0; bus.btn_sw2 = 1'b0; bus.btn_set = 1'b0;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (dut_vec() !== 4'b0000) begin
         n_fail++; $display("FAIL reset_early: got {sw1,sw2,set,ract}=%b, expected 0000", dut_vec());
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (dut_vec() !== 4'b0000) begin
         n_fail++; $display("FAIL reset_held: got %b, expected 0000", dut_vec());
      end
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec() !== 4'b0000) begin
            n_fail++; $display("FAIL reset_idle c=%0d: got %b, expected 0000", c, dut_vec());
         end
      end
   endtask

   task automatic test_single_press();
      logic [3:0] exp;
      settle();
      bus.btn_set = 1'b1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         exp = {2'b00, (c == 7), 1'b0};
         n_checks++;
         if (dut_vec() !== exp) begin
            n_fail++; $display("FAIL single_press c=%0d: got %b, expected %b", c, dut_vec(), exp);
         end
         n_checks++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL single_press_model c=%0d: got %b, expected %b", c, dut_vec(), model_vec());
         end
         if (c == 9) bus.btn_set = 1'b0;
      end
   endtask

   task automatic test_glitch();
      settle();
      bus.btn_sw1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec() !== 4'b0000) begin
            n_fail++; $display("FAIL glitch c=%0d: got %b, expected 0000", c, dut_vec());
         end
         if (c == 2) bus.btn_sw1 = 1'b0;
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp;
      settle();
      bus.btn_sw1 = 1'b1; bus.btn_sw2 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         exp = {(c == 7), (c == 8), 2'b00};
         n_checks++;
         if (dut_vec() !== exp) begin
            n_fail++; $display("FAIL simultaneous c=%0d: got %b, expected %b", c, dut_vec(), exp);
         end
         if (c == 14) begin bus.btn_sw1 = 1'b0; bus.btn_sw2 = 1'b0; end
      end
   endtask

   task automatic test_auto_repeat();
      logic [3:0] exp;
      logic       s, ra;
      settle();
      bus.btn_set = 1'b1;
      for (int c = 0; c < 130; c++) begin
         @(negedge clk);
         s   = (c == 7) || (c >= 39 && c <= 103 && ((c - 39) % 8) == 0);
         ra  = (c >= 39 && c <= 105);
         exp = {2'b00, s, ra};
         n_checks++;
         if (dut_vec() !== exp) begin
            n_fail++; $display("FAIL auto_repeat c=%0d: got %b, expected %b", c, dut_vec(), exp);
         end
         n_checks++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL auto_repeat_model c=%0d: got %b, expected %b", c, dut_vec(), model_vec());
         end
         if (c == 99) bus.btn_set = 1'b0;
      end
   endtask

   task automatic test_repeat_cancel();
      logic [3:0] exp;
      logic       s;
      settle();
      bus.btn_set = 1'b1;
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         s   = (c == 7) || (c == 39) || (c == 47) || (c == 55);
         exp = {1'b0, (c == 58), s, (c >= 39 && c <= 56)};
         n_checks++;
         if (dut_vec() !== exp) begin
            n_fail++; $display("FAIL repeat_cancel c=%0d: got %b, expected %b", c, dut_vec(), exp);
         end
         if (c == 50) bus.btn_sw2 = 1'b1;
         if (c == 60) bus.btn_sw2 = 1'b0;
      end
      bus.btn_set = 1'b0;
   endtask

   task automatic test_reset_mid_repeat();
      logic [3:0] exp;
      settle();
      bus.btn_set = 1'b1;
      repeat (45) @(negedge clk);
      n_checks++;
      if (bus.repeat_active !== 1'b1) begin
         n_fail++; $display("FAIL mid_repeat_active: got %b, expected 1", bus.repeat_active);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (dut_vec() !== 4'b0000) begin
         n_fail++; $display("FAIL async_reset: got %b, expected 0000", dut_vec());
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 39; c++) begin
         @(negedge clk);
         exp = {2'b00, (c == 7), 1'b0};
         n_checks++;
         if (dut_vec() !== exp) begin
            n_fail++; $display("FAIL post_reset c=%0d: got %b, expected %b", c, dut_vec(), exp);
         end
      end
      bus.btn_set = 1'b0;
   endtask

   task automatic test_random();
      int       hold [3];
      bit [2:0] lvl;
      logic     prev_set;
      settle();
      lvl = '0;
      prev_set = 1'b0;
      for (int b = 0; b < 3; b++) hold[b] = int'($urandom_range(5, 40));
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         n_checks++;
         if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL random_model c=%0d: got %b, expected %b", c, dut_vec(), model_vec());
         end
         n_checks++;
         if ($countones({bus.sw1, bus.sw2, bus.set}) > 1) begin
            n_fail++; $display("FAIL random_exclusive c=%0d: got %b, expected at most one pulse", c, dut_vec());
         end
         n_checks++;
         if ((prev_set & bus.set) !== 1'b0) begin
            n_fail++; $display("FAIL random_set_gap c=%0d: got set in consecutive cycles, expected a gap", c);
         end
         prev_set = bus.set;
         for (int b = 0; b < 3; b++) begin
            if (hold[b] == 0) begin
               lvl[b] = ~lvl[b];
               if ($urandom_range(0, 3) == 0)  hold[b] = int'($urandom_range(1, 5));
               else if (b == 2)                hold[b] = lvl[b] ? int'($urandom_range(5, 90))
                                                                : int'($urandom_range(5, 40));
               else                            hold[b] = lvl[b] ? int'($urandom_range(5, 20))
                                                                : int'($urandom_range(30, 150));
            end else begin
               hold[b]--;
            end
         end
         bus.btn_sw1 = lvl[0]; bus.btn_sw2 = lvl[1]; bus.btn_set = lvl[2];
      end
   endtask

   initial begin
      bus.btn_sw1 = 1'b0; bus.btn_sw2 = 1'b0; bus.btn_set = 1'b0;
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_auto_repeat();
      test_repeat_cancel();
      test_reset_mid_repeat();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
